// File: rtl/o_serdes_mc_if.sv
// Parallel word-load handshake between fabric word logic and the o_serdes_mc serializer.
// The fabric side drives words and the load strobe; the serializer returns ready.
interface o_serdes_mc_if #(
  parameter int unsigned NumCh = 2,
  parameter int unsigned Width = 8
) ();
  logic [NumCh*Width-1:0] d;
  logic                   load_word;
  logic                   ready;

  modport master (output d, load_word, input ready);
  modport slave  (input d, load_word, output ready);
endinterface

// File: rtl/o_serdes_mc.sv
// Multi-lane bonded output serializer (SDR/DDR) with a double-buffered word load.
// Optional PRBS7 generator on every lane when O_SERDES_MC_PRBS_EN is defined.
module o_serdes_mc #(
  parameter int unsigned NumCh    = 2,
  parameter int unsigned Width    = 8,
  parameter string       DataRate = "SDR",
  parameter int unsigned PhaseDly = 0,
  parameter bit          LsbFirst = 1'b1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           clk_en_i,
  o_serdes_mc_if.slave                                   word_if,
  input  logic                                           oe_i,
`ifdef O_SERDES_MC_PRBS_EN
  input  logic                                           prbs_mode_i,
`endif
  input  logic                                           chan_bond_sync_i,
  output logic [NumCh*((DataRate == "DDR") ? 2 : 1)-1:0] q_o,
  output logic                                           oe_out_o,
  output logic                                           chan_bond_sync_o,
  output logic                                           underrun_o
);

  localparam int unsigned B     = (DataRate == "DDR") ? 2 : 1;
  localparam int unsigned S     = Width / B;
  localparam int unsigned CntW  = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned PipeW = NumCh * B + 3;

  if (NumCh < 1 || NumCh > 8) begin : gen_bad_num_ch
    $error("o_serdes_mc: NumCh must be 1..8");
  end
  if (Width < 3 || Width > 10) begin : gen_bad_width
    $error("o_serdes_mc: Width must be 3..10");
  end
  if (DataRate != "SDR" && DataRate != "DDR") begin : gen_bad_rate
    $error("o_serdes_mc: DataRate must be SDR or DDR");
  end
  if (DataRate == "DDR" && (Width % 2) != 0) begin : gen_bad_ddr_width
    $error("o_serdes_mc: Width must be even in DDR mode");
  end
  if (PhaseDly > 3) begin : gen_bad_phase
    $error("o_serdes_mc: PhaseDly must be 0..3");
  end

  typedef enum logic {StIdle, StShift} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [NumCh*Width-1:0] hold_q;
  logic                   hold_valid_q;
  logic [Width-1:0]       sr_q [NumCh];
  logic [NumCh*B-1:0]     q_core_q;
  logic                   sync_core_q;
  logic                   oe_core_q;

  logic                   last_slot;
  logic                   xfer;
  logic                   ready;
  logic                   underrun_core;
  logic [Width-1:0]       lane_word [NumCh];

  // Words are bit-reversed on load for MSB-first so the shifter always emits bit 0 first.
  function automatic logic [Width-1:0] order_word(input logic [Width-1:0] w);
    logic [Width-1:0] r;
    for (int i = 0; i < int'(Width); i++) r[i] = w[Width-1-i];
    return LsbFirst ? w : r;
  endfunction

  always_comb begin
    for (int c = 0; c < int'(NumCh); c++) begin
      lane_word[c] = order_word(hold_q[c*Width +: Width]);
    end
  end

`ifdef O_SERDES_MC_PRBS_EN
  logic [6:0]   prbs_q;
  logic [6:0]   prbs_next;
  logic [B-1:0] prbs_bits;

  // x^7 + x^6 + 1, stepped B times per enabled clock; bit 0 is the earlier bit.
  always_comb begin
    prbs_next = prbs_q;
    prbs_bits = '0;
    for (int i = 0; i < int'(B); i++) begin
      prbs_bits[i] = prbs_next[6] ^ prbs_next[5];
      prbs_next    = {prbs_next[5:0], prbs_bits[i]};
    end
  end
`endif

  always_comb begin
    last_slot     = (state_q == StShift) && (cnt_q == CntW'(S - 1));
    xfer          = clk_en_i & hold_valid_q &
                    ((state_q == StIdle) | last_slot | chan_bond_sync_i);
    ready         = ~hold_valid_q | xfer;
    underrun_core = clk_en_i & last_slot & ~hold_valid_q & ~chan_bond_sync_i;
`ifdef O_SERDES_MC_PRBS_EN
    if (prbs_mode_i) begin
      xfer          = 1'b0;
      ready         = 1'b1;
      underrun_core = 1'b0;
    end
`endif
  end

  assign word_if.ready = ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      q_core_q     <= '0;
      sync_core_q  <= 1'b0;
      oe_core_q    <= 1'b0;
      for (int c = 0; c < int'(NumCh); c++) sr_q[c] <= '0;
`ifdef O_SERDES_MC_PRBS_EN
      prbs_q       <= 7'h7F;
`endif
    end else begin
      // Capture ignores clk_en; xfer frees the holding register in the same edge.
      if (word_if.load_word && ready) begin
        hold_q       <= word_if.d;
        hold_valid_q <= 1'b1;
      end else if (xfer) begin
        hold_valid_q <= 1'b0;
      end
      sync_core_q <= xfer;
      oe_core_q   <= oe_i;
`ifdef O_SERDES_MC_PRBS_EN
      if (prbs_mode_i) begin
        if (clk_en_i) begin
          prbs_q <= prbs_next;
          for (int c = 0; c < int'(NumCh); c++) q_core_q[c*B +: B] <= prbs_bits;
        end
        state_q <= StIdle;
        cnt_q   <= '0;
      end else
`endif
      if (xfer) begin
        for (int c = 0; c < int'(NumCh); c++) begin
          q_core_q[c*B +: B] <= lane_word[c][B-1:0];
          sr_q[c]            <= lane_word[c] >> B;
        end
        cnt_q   <= '0;
        state_q <= StShift;
      end else if (clk_en_i) begin
        if (state_q == StShift && !last_slot && !chan_bond_sync_i) begin
          for (int c = 0; c < int'(NumCh); c++) begin
            q_core_q[c*B +: B] <= sr_q[c][B-1:0];
            sr_q[c]            <= sr_q[c] >> B;
          end
          cnt_q <= cnt_q + 1'b1;
        end else begin
          q_core_q <= '0;
          cnt_q    <= '0;
          state_q  <= StIdle;
        end
      end
    end
  end

  logic [PipeW-1:0] core_bus;
  logic [PipeW-1:0] pipe_out;

  assign core_bus = {underrun_core, sync_core_q, oe_core_q, q_core_q};

  if (PhaseDly == 0) begin : gen_no_dly
    assign pipe_out = core_bus;
  end else begin : gen_dly
    logic [PipeW-1:0] dly_q [PhaseDly];

    // Free-running delay line so pulses keep their one-cycle width under clk_en gaps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(PhaseDly); i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= core_bus;
        for (int i = 1; i < int'(PhaseDly); i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign pipe_out = dly_q[PhaseDly-1];
  end

  assign {underrun_o, chan_bond_sync_o, oe_out_o, q_o} = pipe_out;

endmodule

// File: tb/tb_o_serdes_mc.sv
// Directed bench for o_serdes_mc: SDR and PhaseDly=3 instances share stimulus, plus a DDR
// instance; expected lane bits are queued at load time and popped as the serializer emits them.
module tb_o_serdes_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  logic oe = 1'b0;
  logic sync_in = 1'b0;

  always #5 clk = ~clk;

  o_serdes_mc_if #(.NumCh(2), .Width(8))  bus_a ();
  o_serdes_mc_if #(.NumCh(2), .Width(8))  bus_p ();
  o_serdes_mc_if #(.NumCh(2), .Width(10)) bus_d ();

  assign bus_p.d         = bus_a.d;
  assign bus_p.load_word = bus_a.load_word;

  logic [1:0] q_a, q_p;
  logic [3:0] q_d;
  logic       oe_out_a, sync_a, und_a;
  logic       oe_out_p, sync_p, und_p;
  logic       oe_out_d, sync_d, und_d;

  o_serdes_mc #(.NumCh(2), .Width(8), .DataRate("SDR"), .PhaseDly(0), .LsbFirst(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .word_if(bus_a), .oe_i(oe),
`ifdef O_SERDES_MC_PRBS_EN
    .prbs_mode_i(1'b0),
`endif
    .chan_bond_sync_i(sync_in), .q_o(q_a), .oe_out_o(oe_out_a),
    .chan_bond_sync_o(sync_a), .underrun_o(und_a)
  );

  o_serdes_mc #(.NumCh(2), .Width(8), .DataRate("SDR"), .PhaseDly(3), .LsbFirst(1'b1)) dut_p (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .word_if(bus_p), .oe_i(oe),
`ifdef O_SERDES_MC_PRBS_EN
    .prbs_mode_i(1'b0),
`endif
    .chan_bond_sync_i(sync_in), .q_o(q_p), .oe_out_o(oe_out_p),
    .chan_bond_sync_o(sync_p), .underrun_o(und_p)
  );

  o_serdes_mc #(.NumCh(2), .Width(10), .DataRate("DDR"), .PhaseDly(0), .LsbFirst(1'b1)) dut_d (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .word_if(bus_d), .oe_i(oe),
`ifdef O_SERDES_MC_PRBS_EN
    .prbs_mode_i(1'b0),
`endif
    .chan_bond_sync_i(sync_in), .q_o(q_d), .oe_out_o(oe_out_d),
    .chan_bond_sync_o(sync_d), .underrun_o(und_d)
  );

  typedef struct packed {
    logic [3:0] q;
    logic       sync;
    logic       und;
    logic       oe;
  } exp_t;

  exp_t       sb_a [$];
  exp_t       sb_p [$];
  logic [3:0] sb_q [$];
  exp_t       ea, ep;
  logic [3:0] cur;
  logic [7:0] w0, w1;
  logic [13:0] pat;
  logic [19:0] wd [4];
  int         ncap;
  logic       er;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue SDR lane bits first..first+n-1 of {lane1, lane0}.
  task automatic push_sdr(input logic [7:0] l1, input logic [7:0] l0, input int first,
                          input int n);
    for (int j = first; j < first + n; j++) sb_q.push_back({2'b00, l1[j], l0[j]});
  endtask

  function automatic logic [3:0] pop_or_zero();
    if (sb_q.size() > 0) return sb_q.pop_front();
    return 4'h0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.d = '0;
    bus_a.load_word = 1'b0;
    bus_d.d = '0;
    bus_d.load_word = 1'b0;
    #12;
    chk("rst_q", q_a, 0);
    chk("rst_oe_out", oe_out_a, 0);
    chk("rst_ready", bus_a.ready, 1);
    chk("rst_sync", sync_a, 0);
    chk("rst_und", und_a, 0);
    chk("rst_q_ddr", q_d, 0);
    rst_n = 1'b1;
    step();

    // Single word, SDR, compared against the PhaseDly=3 copy.
    w0 = 8'h3C;
    w1 = 8'hA5;
    bus_a.d = {w1, w0};
    bus_a.load_word = 1'b1;
    oe = 1'b1;
    step();
    bus_a.load_word = 1'b0;
    chk("idle_q", q_a, 0);
    for (int j = 0; j < 12; j++) begin
      if (j < 8) sb_a.push_back('{q: {2'b00, w1[j], w0[j]}, sync: (j == 0), und: (j == 7), oe: 1'b1});
      else       sb_a.push_back('{q: 4'h0, sync: 1'b0, und: 1'b0, oe: 1'b0});
    end
    for (int j = 0; j < 12; j++) begin
      if (j >= 3 && j < 11)
        sb_p.push_back('{q: {2'b00, w1[j-3], w0[j-3]}, sync: (j == 3), und: (j == 10), oe: 1'b1});
      else
        sb_p.push_back('{q: 4'h0, sync: 1'b0, und: 1'b0, oe: (j == 2)});
    end
    for (int j = 0; j < 12; j++) begin
      step();
      ea = sb_a.pop_front();
      ep = sb_p.pop_front();
      chk("sdr_q", q_a, ea.q);
      chk("sdr_sync", sync_a, ea.sync);
      chk("sdr_und", und_a, ea.und);
      chk("sdr_oe_out", oe_out_a, ea.oe);
      chk("dly3_q", q_p, ep.q);
      chk("dly3_sync", sync_p, ep.sync);
      chk("dly3_und", und_p, ep.und);
      chk("dly3_oe_out", oe_out_p, ep.oe);
      if (j == 7) oe = 1'b0;
    end

    // clk_en gaps freeze the word; it finishes after 8 enabled edges.
    w0 = 8'h96;
    w1 = 8'h0F;
    bus_a.d = {w1, w0};
    bus_a.load_word = 1'b1;
    step();
    bus_a.load_word = 1'b0;
    push_sdr(w1, w0, 0, 8);
    pat = 14'b11_0111_0100_1101;
    cur = 4'h0;
    for (int i = 0; i < 14; i++) begin
      clk_en = pat[i];
      step();
      if (clk_en) cur = pop_or_zero();
      chk("clken_q", q_a, cur);
    end
    clk_en = 1'b1;

    // Bond sync at cnt=3 with a word waiting.
    w0 = 8'h5A;
    w1 = 8'hC3;
    bus_a.d = {w1, w0};
    bus_a.load_word = 1'b1;
    step();
    push_sdr(w1, w0, 0, 4);
    w0 = 8'h7E;
    w1 = 8'h81;
    bus_a.d = {w1, w0};
    for (int i = 1; i <= 13; i++) begin
      step();
      chk("bond_q", q_a, pop_or_zero());
      chk("bond_sync", sync_a, (i == 1 || i == 5));
      chk("bond_und", und_a, (i == 12));
      if (i == 1) bus_a.load_word = 1'b0;
      if (i == 4) begin
        sync_in = 1'b1;
        push_sdr(w1, w0, 0, 8);
      end
      if (i == 5) sync_in = 1'b0;
    end

    // Asynchronous reset mid-word with a load pending.
    bus_a.d = {8'hFF, 8'h81};
    bus_a.load_word = 1'b1;
    oe = 1'b1;
    step();
    bus_a.load_word = 1'b0;
    repeat (6) step();
    chk("pre_rst_q", q_a, 2'b10);
    chk("pre_rst_oe_out", oe_out_a, 1);
    bus_a.d = 16'hFFFF;
    bus_a.load_word = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", q_a, 0);
    chk("mid_rst_oe_out", oe_out_a, 0);
    chk("mid_rst_ready", bus_a.ready, 1);
    chk("mid_rst_sync", sync_a, 0);
    bus_a.load_word = 1'b0;
    oe = 1'b0;
    #2;
    rst_n = 1'b1;
    bus_a.d = {8'h5A, 8'h33};
    bus_a.load_word = 1'b1;
    step();
    bus_a.load_word = 1'b0;
    chk("post_rst_idle_q", q_a, 0);
    step();
    chk("post_rst_q0", q_a, 2'b01);
    chk("post_rst_sync", sync_a, 1);
    step();
    chk("post_rst_q1", q_a, 2'b11);
    repeat (7) step();
    chk("post_rst_end_q", q_a, 0);

    // DDR, Width=10: load held high, words stream back-to-back.
    wd[0] = 20'hA5C3F;
    wd[1] = 20'h1E2D4;
    wd[2] = 20'hFFF00;
    wd[3] = 20'h0369C;
    ncap = 0;
    for (int t = 0; t < 22; t++) begin
      bus_d.load_word = (ncap < 4);
      bus_d.d = wd[(ncap < 4) ? ncap : 3];
      er = (t <= 1) || (t >= 6 && ((t - 1) % 5) == 0);
      if (t <= 11) chk("ddr_ready", bus_d.ready, er);
      if (ncap < 4 && er) begin
        for (int s = 0; s < 5; s++) begin
          sb_q.push_back({wd[ncap][10+2*s+1], wd[ncap][10+2*s], wd[ncap][2*s+1], wd[ncap][2*s]});
        end
        ncap++;
      end
      step();
      cur = (t >= 1) ? pop_or_zero() : 4'h0;
      chk("ddr_q", q_d, cur);
      chk("ddr_sync", sync_d, (t >= 1 && t <= 16 && ((t - 1) % 5) == 0));
      chk("ddr_und", und_d, (t == 20));
    end
    bus_d.load_word = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
